// File: rtl/result_stream_checker.sv
// Self-check monitor: snoops the CPU write bus and scores test-port writes
// against a runtime-loaded expected-value table after a begin symbol.
module result_stream_checker #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                IDX_W     = 8,
    parameter logic [ADDR_W-1:0] TEST_PORT = 30'h0FF,
    parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000932,
    parameter logic [DATA_W-1:0] END_SYM   = 32'h00000D5D,
    parameter int                ERR_W     = 8,
    parameter int                DUR_W     = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [IDX_W:0]    exp_len,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic [IDX_W:0]    checked,
    output logic              finish,
    output logic              pass,
    output logic              short_run,
    output logic              timed_out,
    output logic              first_err_valid,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_REPORT, S_TIMEOUT} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_wen_d;
    logic [DATA_W-1:0] r_tbl [DEPTH];
    logic [ERR_W-1:0]  r_err, w_err_nxt;
    logic [DUR_W-1:0]  r_dur, w_dur_nxt;
    logic [IDX_W:0]    r_chk, w_chk_nxt;
    logic              r_short, w_short_nxt;
    logic              r_to, w_to_nxt;
    logic              r_fv, w_fv_nxt;
    logic [IDX_W-1:0]  r_fi, w_fi_nxt;
    logic [DATA_W-1:0] r_fd, w_fd_nxt;

    logic              w_sample;
    logic [DATA_W-1:0] w_exp;
    logic              w_to_hit;

    // A stalled store keeps wen high for several cycles; only its first cycle counts.
    assign w_sample = wen && !r_wen_d && (addr == TEST_PORT);
    assign w_exp    = r_tbl[r_chk[IDX_W-1:0]];
    assign w_to_hit = (({1'b0, r_dur} + (DUR_W+1)'(1)) == {1'b0, TIMEOUT});

    // Table is deliberately left out of reset so one load survives reruns.
    always_ff @(posedge clk) begin
        if (tbl_we && r_state == S_IDLE)
            r_tbl[tbl_addr] <= tbl_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_dur_nxt   = r_dur;
        w_chk_nxt   = r_chk;
        w_short_nxt = r_short;
        w_to_nxt    = r_to;
        w_fv_nxt    = r_fv;
        w_fi_nxt    = r_fi;
        w_fd_nxt    = r_fd;
        case (r_state)
            S_IDLE: begin
                if (w_sample && data == BEGIN_SYM) begin
                    w_state_nxt = S_CHECK;
                    w_err_nxt   = '0;
                    w_chk_nxt   = '0;
                    w_dur_nxt   = '0;
                end
            end
            S_CHECK: begin
                w_dur_nxt = (r_dur == '1) ? r_dur : r_dur + DUR_W'(1);
                if (r_chk == exp_len) begin
                    w_state_nxt = S_REPORT;
                end else if (w_sample && data == END_SYM && r_chk < exp_len
                             && w_exp != END_SYM) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = S_REPORT;
                end else if (w_sample) begin
                    if (data != w_exp) begin
                        w_err_nxt = (r_err == '1) ? r_err : r_err + ERR_W'(1);
                        if (!r_fv) begin
                            w_fv_nxt = 1'b1;
                            w_fi_nxt = r_chk[IDX_W-1:0];
                            w_fd_nxt = data;
                        end
                    end
                    w_chk_nxt = (r_chk == '1) ? r_chk : r_chk + (IDX_W+1)'(1);
                end
                // Timeout overrides a completion decided on the same edge.
                if (w_to_hit) begin
                    w_to_nxt    = 1'b1;
                    w_state_nxt = S_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wen_d <= 1'b0;
            r_err   <= '1;
            r_dur   <= '0;
            r_chk   <= '0;
            r_short <= 1'b0;
            r_to    <= 1'b0;
            r_fv    <= 1'b0;
            r_fi    <= '0;
            r_fd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wen_d <= wen;
            r_err   <= w_err_nxt;
            r_dur   <= w_dur_nxt;
            r_chk   <= w_chk_nxt;
            r_short <= w_short_nxt;
            r_to    <= w_to_nxt;
            r_fv    <= w_fv_nxt;
            r_fi    <= w_fi_nxt;
            r_fd    <= w_fd_nxt;
        end
    end

    assign error_num       = r_err;
    assign duration        = r_dur;
    assign checked         = r_chk;
    assign short_run       = r_short;
    assign timed_out       = r_to;
    assign first_err_valid = r_fv;
    assign first_err_idx   = r_fi;
    assign first_err_data  = r_fd;
    assign finish          = (r_state == S_REPORT) || (r_state == S_TIMEOUT);
    assign pass            = finish && (r_err == '0) && !r_short && !r_to;

endmodule

// File: doc/result_stream_checker.md
Name: result_stream_checker

Overview:
- Synthesizable, parametrised self-check monitor for the L1/L2 cache test benches.
- Snoops the CPU data-memory write bus. After a begin symbol is written to the test port, it compares every later test-port write against a runtime-loadable expected-value table.
- Reports error count, cycle duration, first-mismatch capture, short-run and timeout status.
- Replaces per-test hard-coded answer ROMs: one instance serves every program, with the table loaded before release.

Parameters:
ADDR_W, 30, width of monitored word address
DATA_W, 32, width of monitored data and expected entries
DEPTH, 256, expected-table entries (power of two)
IDX_W, 8, log2(DEPTH)
TEST_PORT, 30'h0FF, word address treated as the test port
BEGIN_SYM, 32'h00000932, data value that starts checking
END_SYM, 32'h00000D5D, data value that terminates checking early
ERR_W, 8, error counter width
DUR_W, 16, duration counter width
TIMEOUT, 16'hFFFF, duration value that forces timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr  in  ADDR_W  monitored write address
data  in  DATA_W  monitored write data
wen  in  1  monitored write enable (may stay high several cycles during stalls)
tbl_we  in  1  expected-table write strobe
tbl_addr  in  IDX_W  expected-table write index
tbl_data  in  DATA_W  expected-table write data
exp_len  in  IDX_W+1  number of entries to check, 0..DEPTH
error_num  out  ERR_W  mismatch count
duration  out  DUR_W  cycles spent in CHECK
checked  out  IDX_W+1  entries compared so far
finish  out  1  run complete (REPORT or TIMEOUT)
pass  out  1  finish & error_num==0 & !short_run & !timed_out
short_run  out  1  END_SYM arrived before exp_len entries
timed_out  out  1  duration reached TIMEOUT
first_err_valid  out  1  a mismatch has been captured
first_err_idx  out  IDX_W  index of first mismatch
first_err_data  out  DATA_W  observed data of first mismatch

Behaviour:
- Reset (sync, active-high, overrides everything):
  - state=IDLE, checked=0, duration=0, error_num=all ones.
  - short_run, timed_out, first_err_valid = 0; first_err_idx=0, first_err_data=0.
  - Table contents are NOT cleared.
- Write qualification: a write counts only on the first cycle of a wen-high burst. Implemented as wen & ~wen_d, with wen_d registered and reset to 0. A sample = qualified write with addr==TEST_PORT.
- Table:
  - tbl_we writes tbl_data to entry tbl_addr at the clock edge, accepted only in IDLE; ignored in all other states.
  - Read is combinational, indexed by checked[IDX_W-1:0].
- States:
  - IDLE: sample with data==BEGIN_SYM -> CHECK; error_num:=0, checked:=0, duration:=0. Other samples are ignored. A table write and a begin sample in the same cycle both take effect.
  - CHECK:
    - duration increments every cycle, saturating.
    - If checked==exp_len, go to REPORT this edge; any sample in that cycle is ignored.
    - Else, if a sample has data==END_SYM and checked<exp_len and table[checked]!=END_SYM: set short_run=1, no error increment, go to REPORT.
    - Else, on a sample: compare with table[checked]. On mismatch, error_num+1 (saturating at all ones). If first_err_valid==0, capture first_err_idx=checked, first_err_data=data, and set first_err_valid. Then checked+1.
    - If duration+1==TIMEOUT: timed_out=1, go to TIMEOUT. This has priority over a completion in the same cycle; that cycle's sample is still scored.
  - REPORT, TIMEOUT: all counters frozen; finish=1; exits only via rst.
- exp_len==0: begin -> CHECK, next edge -> REPORT with duration=1, error_num=0.
- finish is combinational from state: high starting the cycle after the edge that enters REPORT/TIMEOUT.
- Width rules: all counters are unsigned, saturating, with no wrap.

Test Plan:
- Load table [0,1,1,2], exp_len=4, write BEGIN then 0,1,1,2 -> finish=1, pass=1, error_num=0, checked=4.
- Same table; hold wen high 3 cycles on each write -> each write scored once; error_num=0.
- Write 0,5,1,9 -> error_num=2, first_err_idx=1, first_err_data=5, pass=0.
- exp_len=4; after 2 good samples, write END_SYM -> short_run=1, finish=1, checked=2, pass=0.
- TIMEOUT=16'd20; BEGIN then no further writes -> timed_out=1 and finish after duration=20; duration holds at 20.
- Assert rst in CHECK after 2 samples -> next cycle IDLE, error_num=8'hFF, finish=0. Table retained: a rerun with 0,1,1,2 passes without reload. A tbl_we issued in CHECK has no effect.
